apu_wb_queue: RTL

//   Write-back queue between the APU result path and the register file's APU

---
 rtl/apu_wb_queue.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apu_wb_queue.sv
// apu_wb_queue: write-back FIFO between the APU result path and the
// register-file APU write port. It issues one single-cycle request per
// stored entry, waits for the ack, and exports a per-register pending bitmap
// so the issue logic can stall on RAW hazards.
module apu_wb_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_SEL_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REG_SEL_WIDTH-1:0]     in_sel,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         apu_wr_req,
    input  logic                         apu_ack,
    output logic [REG_SEL_WIDTH-1:0]     apu_wr_sel,
    output logic [DATA_WIDTH-1:0]        apu_wr_data,
    output logic [NUM_REGS-1:0]          pending,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      req_q, req_d;
    logic [REG_SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;

    logic [REG_SEL_WIDTH-1:0]  sel_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_q [DEPTH];

    logic                      full_w;
    logic                      accept;
    logic                      store;
    logic                      pop;
    logic [PW-1:0]             next_head;
    logic [NUM_REGS-1:0]       pend_w;

    // Flags derived from the registered count; in_ready never sees a same-cycle pop.
    always_comb begin
        full_w   = (count_q == CW'(DEPTH));
        in_ready = !full_w;
        full     = full_w;
        empty    = (count_q == '0);
        count    = count_q;
    end

    // Handshake decode: register 0 is a sink, so its results complete but are not stored.
    always_comb begin
        accept    = in_valid && !full_w;
        store     = accept && (in_sel != '0);
        pop       = (state_q == S_WAIT) && apu_ack;
        next_head = rd_ptr_q + PW'(1);
    end

    // Pointer and occupancy bookkeeping.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = next_head;
        end
        case ({store, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: next state plus the registered request/select/data outputs.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = S_ISSUE;
                    sel_d   = sel_mem_q[rd_ptr_q];
                    data_d  = data_mem_q[rd_ptr_q];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (apu_ack) begin
                    // The next head is either an older stored entry or the
                    // result being pushed on this very edge when the pop empties the FIFO.
                    if (count_q > CW'(1)) begin
                        state_d = S_ISSUE;
                        sel_d   = sel_mem_q[next_head];
                        data_d  = data_mem_q[next_head];
                    end else if (store) begin
                        state_d = S_ISSUE;
                        sel_d   = in_sel;
                        data_d  = in_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d = (state_d == S_ISSUE);
    end

    // State, pointer and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            req_q    <= req_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
        end
    end

    // Entry storage; slots are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (store) begin
            sel_mem_q[wr_ptr_q]  <= in_sel;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Pending bitmap: OR of one-hot selects over the live entries, head included.
    always_comb begin
        pend_w = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(count_q)) begin
                pend_w[sel_mem_q[rd_ptr_q + PW'(i)]] = 1'b1;
            end
        end
        pend_w[0] = 1'b0;
    end

    // Registered FSM outputs and the pending bitmap drive the ports.
    always_comb begin
        apu_wr_req  = req_q;
        apu_wr_sel  = sel_q;
        apu_wr_data = data_q;
        pending     = pend_w;
    end

endmodule
